// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types.
// Register file and ALU agree on word and register-index widths through this package.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: index mux, zero-register force
// and an optional same-cycle write-data bypass enabled per instance.
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DEPTH  = 2 ** cpu_pkg::ADDR_W,
    parameter bit BYPASS = 1'b0
) (
    input  logic              rst_n,
    input  logic [DATA_W-1:0] regs [DEPTH],
    input  logic [ADDR_W-1:0] idx,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

    // A nonzero idx matching wr_idx already implies the write is not to r0.
    always_comb begin
        data = '0;
        if (rst_n && idx != ADDR_W'(ZERO_REG)) begin
            if (BYPASS && wr_en && idx == wr_idx) begin
                data = wr_data;
            end else begin
                data = regs[idx];
            end
        end
    end

endmodule

// File: rtl/regfile32.sv
// Architectural register file: two operand read ports, one write port, one debug port.
// Define REGFILE_WRITE_BYPASS_EN for write-first operand reads.
module regfile32
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DEPTH  = 2 ** cpu_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              RegWre,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] DbgData
);

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit OPERAND_BYPASS = 1'b1;
`else
    localparam bit OPERAND_BYPASS = 1'b0;
`endif

    generate
        if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
            $error("regfile32: DEPTH must equal 2**ADDR_W");
        end
    endgenerate

    logic [DATA_W-1:0] regs [DEPTH];

    // r0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWre && WriteReg != ADDR_W'(ZERO_REG)) begin
            regs[WriteReg] <= WriteData;
        end
    end

    regfile_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BYPASS(OPERAND_BYPASS)
    ) u_port1 (
        .rst_n   (RST_n),
        .regs    (regs),
        .idx     (ReadReg1),
        .wr_en   (RegWre),
        .wr_idx  (WriteReg),
        .wr_data (WriteData),
        .data    (ReadData1)
    );

    regfile_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BYPASS(OPERAND_BYPASS)
    ) u_port2 (
        .rst_n   (RST_n),
        .regs    (regs),
        .idx     (ReadReg2),
        .wr_en   (RegWre),
        .wr_idx  (WriteReg),
        .wr_data (WriteData),
        .data    (ReadData2)
    );

    // The debug port always shows committed state, never in-flight write data.
    regfile_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BYPASS(1'b0)
    ) u_dbg_port (
        .rst_n   (RST_n),
        .regs    (regs),
        .idx     (DbgAddr),
        .wr_en   (RegWre),
        .wr_idx  (WriteReg),
        .wr_data (WriteData),
        .data    (DbgData)
    );

endmodule

// File: tb/tb_regfile32.sv
// Self-checking bench for regfile32: a behavioural register-array model checked
// every negative edge, plus directed literal checks at the interesting moments.
module tb_regfile32;

    logic        clk;
    logic        rst_n;
    logic        reg_wre;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  dbg_addr;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] dbg_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_mem [32];

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    regfile32 dut (
        .CLK       (clk),
        .RST_n     (rst_n),
        .RegWre    (reg_wre),
        .ReadReg1  (read_reg1),
        .ReadReg2  (read_reg2),
        .WriteReg  (write_reg),
        .WriteData (write_data),
        .DbgAddr   (dbg_addr),
        .ReadData1 (read_data1),
        .ReadData2 (read_data2),
        .DbgData   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a plain array of 32 words; reset empties it, an enabled write to a
    // nonzero index replaces one word at the rising edge.
    initial begin
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1 && reg_wre === 1'b1 && write_reg != 5'd0)
            model_mem[write_reg] = write_data;
    end

    function automatic logic [31:0] expect_read(input logic [4:0] idx, input bit operand_port);
        if (rst_n !== 1'b1) return 32'h0;
        if (idx == 5'd0) return 32'h0;
        if (operand_port && BYPASS && reg_wre === 1'b1 && idx == write_reg) return write_data;
        return model_mem[idx];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare all three ports against the model in the middle of every cycle.
    always @(negedge clk) begin
        checkOutput("model_rd1", read_data1, expect_read(read_reg1, 1'b1));
        checkOutput("model_rd2", read_data2, expect_read(read_reg2, 1'b1));
        checkOutput("model_dbg", dbg_data,   expect_read(dbg_addr, 1'b0));
    end

    // Apply a full input vector two time units after the rising edge.
    task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
        @(posedge clk);
        #2;
        reg_wre    = we;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        dbg_addr   = dbg;
    endtask

    task automatic tickThenSettle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        reg_wre = 1'b0;
        write_reg = 5'd0;
        write_data = 32'h0;
        read_reg1 = 5'd1;
        read_reg2 = 5'd2;
        dbg_addr = 5'd3;

        #12;
        checkOutput("reset_rd1", read_data1, 32'h0);
        checkOutput("reset_rd2", read_data2, 32'h0);
        checkOutput("reset_dbg", dbg_data, 32'h0);
        rst_n = 1'b1;

        // A few distinct patterns across the array.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5);
        applyStimulus(1'b1, 5'd31, 32'h8000_0001, 5'd5, 5'd31, 5'd5);
        applyStimulus(1'b1, 5'd1, 32'h0F0F_F0F0, 5'd31, 5'd5, 5'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd1);
        #1;
        checkOutput("r5_written", read_data1, 32'hDEADBEEF);
        checkOutput("r31_written", read_data2, 32'h8000_0001);
        checkOutput("r1_written", dbg_data, 32'h0F0F_F0F0);

        // Asynchronous reset mid-cycle clears everything at once.
        read_reg2 = 5'd5;
        dbg_addr = 5'd5;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_rd1", read_data1, 32'h0);
        checkOutput("async_rst_rd2", read_data2, 32'h0);
        checkOutput("async_rst_dbg", dbg_data, 32'h0);
        tickThenSettle();
        rst_n = 1'b1;
        #1;
        checkOutput("r5_after_rst", read_data1, 32'h0);

        // Basic write then read on all three ports.
        applyStimulus(1'b1, 5'd8, 32'h12345678, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 5'd8);
        #1;
        checkOutput("r8_rd1", read_data1, 32'h12345678);
        checkOutput("r8_rd2", read_data2, 32'h12345678);
        checkOutput("r8_dbg", dbg_data, 32'h12345678);

        // Writes to r0 are dropped, before and after the edge.
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        #1;
        checkOutput("r0_before", read_data1, 32'h0);
        tickThenSettle();
        reg_wre = 1'b0;
        #1;
        checkOutput("r0_after", read_data1, 32'h0);

        // Write enable low leaves r3 alone.
        applyStimulus(1'b1, 5'd3, 32'h00000011, 5'd3, 5'd0, 5'd3);
        applyStimulus(1'b0, 5'd3, 32'hAAAA5555, 5'd3, 5'd0, 5'd3);
        tickThenSettle();
        #1;
        checkOutput("r3_kept", read_data1, 32'h00000011);

        // Read during write on r9.
        applyStimulus(1'b1, 5'd9, 32'h1, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd9, 32'h2, 5'd0, 5'd9, 5'd9);
        #1;
        checkOutput("rdw_before_rd2", read_data2, BYPASS ? 32'h2 : 32'h1);
        checkOutput("rdw_before_dbg", dbg_data, 32'h1);
        tickThenSettle();
        reg_wre = 1'b0;
        #1;
        checkOutput("rdw_after_rd2", read_data2, 32'h2);
        checkOutput("rdw_after_dbg", dbg_data, 32'h2);

        // Reset held across an edge wins over a simultaneous write to r7.
        applyStimulus(1'b1, 5'd7, 32'h77, 5'd7, 5'd7, 5'd7);
        @(negedge clk);
        rst_n = 1'b0;
        reg_wre = 1'b1;
        write_reg = 5'd7;
        write_data = 32'h55;
        tickThenSettle();
        reg_wre = 1'b0;
        rst_n = 1'b1;
        #1;
        checkOutput("collision_r7", read_data1, 32'h0);
        checkOutput("collision_dbg", dbg_data, 32'h0);

        // Both operand ports on the same register after a fresh write.
        applyStimulus(1'b1, 5'd12, 32'hCAFE_F00D, 5'd12, 5'd12, 5'd12);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 5'd12, 5'd12);
        #1;
        checkOutput("same_reg_rd1", read_data1, 32'hCAFE_F00D);
        checkOutput("same_reg_rd2", read_data2, 32'hCAFE_F00D);

        tickThenSettle();
        tickThenSettle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile32.md
Name: regfile32

Overview:
- Architectural general-purpose register file for the single-cycle CPU.
- Sits directly upstream of the ALU. ReadData1 and ReadData2 drive the ALU operand inputs, either directly or through the operand-B source mux.
- Two combinational read ports, one synchronous write port, and one extra read-only debug port for board display.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width.
- DEPTH, 32, number of registers; must equal 2**ADDR_W.

Ports:
- CLK  input  1  system clock; all writes occur on the rising edge.
- RST_n  input  1  asynchronous, active-low reset; clears every register.
- RegWre  input  1  write enable for the write port.
- ReadReg1  input  ADDR_W  read port 1 index (rs).
- ReadReg2  input  ADDR_W  read port 2 index (rt).
- WriteReg  input  ADDR_W  write port index (rd or rt, selected upstream).
- WriteData  input  DATA_W  write data (ALU result or memory data, selected upstream).
- DbgAddr  input  ADDR_W  debug read index.
- ReadData1  output  DATA_W  contents of register ReadReg1.
- ReadData2  output  DATA_W  contents of register ReadReg2.
- DbgData  output  DATA_W  contents of register DbgAddr.

Behaviour:
- Storage: DEPTH x DATA_W flops; no RAM inference required.
- Reset:
  - RST_n low clears all registers to 0 immediately, with no dependence on CLK.
  - While RST_n is low, ReadData1, ReadData2 and DbgData all read 0.
  - Reset dominates a simultaneous write: no write takes effect in any cycle where RST_n is low at the rising edge.
- Write:
  - At the rising edge of CLK, if RST_n is high, RegWre is 1 and WriteReg != 0, then reg[WriteReg] <= WriteData.
  - Writes with WriteReg == 0 are silently dropped.
  - RegWre = 0 leaves all registers unchanged.
- Read:
  - All three read ports are purely combinational with zero-cycle latency, as required by a single-cycle datapath.
  - An index of 0 always returns 0.
  - Any other index returns the currently stored value.
- Read-during-write, without the optional feature: a port whose index equals WriteReg returns the old value until the edge, and the new value after it.
- Both read ports may address the same register; each returns the identical value.
- An index is never out of range, since DEPTH == 2**ADDR_W. An elaboration check must flag any mismatch.
- There is no handshake and no stall: one write per cycle, unlimited reads.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- When defined:
  - A read port returns WriteData combinationally whenever RegWre = 1, WriteReg != 0, and its index equals WriteReg. This gives write-first semantics for a later pipelined datapath.
  - The bypass applies to ReadData1 and ReadData2 only.
  - DbgData always shows stored state.
  - No bypass occurs while RST_n is low; outputs read 0.
- When undefined: no bypass path exists; reads follow the read-during-write rule above.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and ADDR_W constants.
  - ZERO_REG = 0.
  - A reg_idx_t typedef (ADDR_W bits).
  - A word_t typedef (DATA_W bits).
- One natural sub-module, regfile_read_port, is instantiated three times. It contains:
  - the index mux;
  - the zero-register force;
  - the optional bypass compare, enabled per instance.

Test Plan:
- Reset: drive RST_n low mid-cycle, asynchronously, after earlier writes of 0xDEADBEEF to r5 -> all three ports read 0 immediately. After RST_n releases, r5 still reads 0.
- Basic write/read:
  - Write r8 = 0x12345678 with RegWre = 1.
  - Next cycle set ReadReg1 = 8, ReadReg2 = 8, DbgAddr = 8 -> all read 0x12345678.
- Zero register: write r0 = 0xFFFFFFFF -> ReadData1 with ReadReg1 = 0 reads 0 before and after the edge.
- Write enable off: RegWre = 0, WriteReg = 3, WriteData = 0xAAAA5555 -> r3 keeps its prior value 0x00000011.
- Read-during-write: r9 = 1, then write r9 = 2 with ReadReg2 = 9 in the same cycle:
  - Without the macro: 1 before the edge, 2 after.
  - With REGFILE_WRITE_BYPASS_EN: 2 before the edge, while DbgData (DbgAddr = 9) still shows 1.
- Reset vs write collision: RST_n low at the edge with RegWre = 1, WriteReg = 7, WriteData = 0x55 -> r7 reads 0 after reset release.
